// File: rtl/writeback_queue_if.sv
// Writeback queue bus: upstream push handshake, result sources, register
// file drain side, forwarding lookup and retire counter.
// master = producer/consumer environment, slave = the queue itself.
interface writeback_queue_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
);
   logic              in_valid;
   logic              in_ready;
   logic              RegWrite;
   logic [1:0]        resSel;
   logic [WIDTH-1:0]  ALUResult;
   logic [WIDTH-1:0]  StoreMem;
   logic [WIDTH-1:0]  linkPC;
   logic [WIDTH-1:0]  immVal;
   logic [ADDR_W-1:0] rdWB;
   logic              flush;
   logic              rf_ready;
   logic [WIDTH-1:0]  loadData;
   logic [ADDR_W-1:0] loadAddr;
   logic              regWriteOut;
   logic [ADDR_W-1:0] fwd_rs;
   logic              fwd_hit;
   logic [WIDTH-1:0]  fwd_data;
   logic [15:0]       retire_count;

   modport master (
      output in_valid, RegWrite, resSel, ALUResult, StoreMem, linkPC, immVal,
             rdWB, flush, rf_ready, fwd_rs,
      input  in_ready, loadData, loadAddr, regWriteOut, fwd_hit, fwd_data,
             retire_count
   );

   modport slave (
      input  in_valid, RegWrite, resSel, ALUResult, StoreMem, linkPC, immVal,
             rdWB, flush, rf_ready, fwd_rs,
      output in_ready, loadData, loadAddr, regWriteOut, fwd_hit, fwd_data,
             retire_count
   );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: small FIFO of {RegWrite, rd, data} entries between the
// result mux and the register file write port. Entries that do not write a
// real register drain without waiting for the register file.
// Optional macro WB_FORWARD_EN adds a combinational lookup of buffered
// entries (youngest match wins); without it fwd_hit/fwd_data are tied to 0.
module writeback_queue #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2
) (
   input logic             clk,
   input logic             reset,
   writeback_queue_if.slave bus
);

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0]  data_q [DEPTH];
   logic [WIDTH-1:0]  data_d [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic              we_q   [DEPTH];
   logic              we_d   [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [15:0]       retire_q, retire_d;

   logic              non_empty;
   logic              ready;
   logic              wr_present;
   logic              push;
   logic              pop;
   logic [WIDTH-1:0]  sel_data;
   logic              fwd_hit_c;
   logic [WIDTH-1:0]  fwd_data_c;

   // Result source mux, evaluated at push time.
   always_comb begin
      case (bus.resSel)
         2'd0:    sel_data = bus.ALUResult;
         2'd1:    sel_data = bus.StoreMem;
         2'd2:    sel_data = bus.linkPC;
         default: sel_data = bus.immVal;
      endcase
   end

   // Handshake decode: ready depends on occupancy only; x0 writes never present.
   always_comb begin
      non_empty  = (count_q != '0);
      ready      = (count_q < CNT_W'(DEPTH));
      wr_present = non_empty & we_q[head_q] & (addr_q[head_q] != '0);
      push       = bus.in_valid & ready & ~bus.flush;
      pop        = non_empty & ~bus.flush & (bus.rf_ready | ~wr_present);
   end

   // Next-state for pointers, occupancy, retire counter and entry storage.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      retire_d = retire_q;
      data_d   = data_q;
      addr_d   = addr_q;
      we_d     = we_q;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            data_d[tail_q] = sel_data;
            addr_d[tail_q] = bus.rdWB;
            we_d[tail_q]   = bus.RegWrite;
            tail_d         = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (pop && wr_present && bus.rf_ready) begin
            retire_d = retire_q + 16'd1;
         end
      end
   end

   // Control state; reset wins over flush, push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         retire_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         retire_q <= retire_d;
      end
   end

   // Entry storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      addr_q <= addr_d;
      we_q   <= we_d;
   end

`ifdef WB_FORWARD_EN
   logic [PTR_W-1:0] idx;

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && we_q[idx] &&
             (addr_q[idx] == bus.fwd_rs) && (bus.fwd_rs != '0)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = data_q[idx];
         end
      end
   end
`else
   // Forwarding disabled: no lookup, outputs held at zero.
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
   end
`endif

   // Head presentation; fields read as zero while the queue is empty.
   always_comb begin
      bus.in_ready     = ready;
      bus.loadData     = non_empty ? data_q[head_q] : '0;
      bus.loadAddr     = non_empty ? addr_q[head_q] : '0;
      bus.regWriteOut  = wr_present;
      bus.retire_count = retire_q;
      bus.fwd_hit      = fwd_hit_c;
      bus.fwd_data     = fwd_data_c;
   end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter WIDTH, default 16, data width of every result source and of loadData.
REQ-002 Parameter ADDR_W, default 3, destination register address width.
REQ-003 Parameter DEPTH, default 2, number of buffer entries; power of two, 2 to 8.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 Port in_valid  in  1  upstream offers one writeback entry.
REQ-007 Port in_ready  out  1  queue can accept an entry this cycle.
REQ-008 Port RegWrite  in  1  entry requests a register write.
REQ-009 Port resSel  in  2  result source select: 0 ALUResult, 1 StoreMem, 2 linkPC, 3 immVal.
REQ-010 Port ALUResult, StoreMem, linkPC, immVal  in  WIDTH each  candidate result values.
REQ-011 Port rdWB  in  ADDR_W  destination register address.
REQ-012 Port flush  in  1  discard all buffered entries.
REQ-013 Port rf_ready  in  1  register file accepts the head entry this cycle.
REQ-014 Port loadData  out  WIDTH  head entry data.
REQ-015 Port loadAddr  out  ADDR_W  head entry address.
REQ-016 Port regWriteOut  out  1  head entry performs a register write this cycle.
REQ-017 Port fwd_rs  in  ADDR_W  source register address for forwarding lookup.
REQ-018 Port fwd_hit, fwd_data  out  1, WIDTH  forwarding match flag and value.
REQ-019 Port retire_count  out  16  count of completed register writes.

Function
REQ-020 Push: in_valid & in_ready & ~flush stores {RegWrite, rdWB, selected source} at the tail on the rising edge; resSel is decoded at push time.
REQ-021 in_ready = (count < DEPTH); it depends on count only, so a full queue refuses a push even when a pop occurs in the same cycle.
REQ-022 Latency: an entry pushed into an empty queue at edge k is on loadData/loadAddr from edge k until it is popped.
REQ-023 Outputs: loadData/loadAddr = head fields when count > 0, else 0; regWriteOut = (count > 0) & head.RegWrite & (head.rdWB != 0).
REQ-024 Pop: the head is removed when count > 0 & ~flush & (rf_ready | ~regWriteOut); entries with no write, or with rdWB = 0, drain without waiting for rf_ready.
REQ-025 Push and pop in the same cycle leave count unchanged; order is strictly FIFO; pointers wrap modulo DEPTH.
REQ-026 flush: count, head and tail pointers become 0 on the next edge; a same-cycle push is dropped and retire_count does not increment.
REQ-027 retire_count increments by 1 on each pop with regWriteOut = 1 and rf_ready = 1; wraps 0xFFFF to 0x0000.
REQ-028 Address 0 is the hardwired zero register; a write to it is never presented and never counted.

Reset
REQ-029 reset on a clock edge sets count, pointers and retire_count to 0, so loadData, loadAddr, regWriteOut, fwd_hit, fwd_data and retire_count read 0 and in_ready reads 1 after that edge.
REQ-030 reset takes priority over push, pop and flush; entries held mid-operation are discarded.

Configuration
REQ-031 Macro WB_FORWARD_EN defined: fwd_hit = 1 when a valid entry has RegWrite = 1, rdWB = fwd_rs and fwd_rs != 0; fwd_data is the youngest such entry's data; combinational, covering buffered entries only.
REQ-032 Macro WB_FORWARD_EN undefined: no lookup logic; fwd_hit and fwd_data are tied to 0.

Verification
REQ-033 Assert reset 1 cycle with in_valid = 1, ALUResult = 0xAAAA, rdWB = 5 -> after the edge all outputs 0, in_ready = 1, retire_count = 0.
REQ-034 Push resSel = 0, ALUResult = 0xAAAA, rdWB = 5, RegWrite = 1, rf_ready = 1 -> next cycle loadData = 0xAAAA, loadAddr = 5, regWriteOut = 1; retire_count = 1 one cycle later.
REQ-035 rf_ready = 0, push 2 entries (resSel = 1, StoreMem = 0xBBBB, rd = 3; resSel = 2, linkPC = 0x0010, rd = 4) -> in_ready = 0, head holds 0xBBBB; a third push is refused; raise rf_ready -> 0xBBBB then 0x0010 retire in order.
REQ-036 Push RegWrite = 1, rdWB = 0, rf_ready = 0 -> regWriteOut = 0, entry drains next edge, retire_count unchanged.
REQ-037 Full queue, flush = 1 with in_valid = 1 -> next cycle in_ready = 1, regWriteOut = 0, dropped push absent.
REQ-038 With WB_FORWARD_EN, rf_ready = 0, entries rd = 2 data 0x1111 then rd = 2 data 0x2222, fwd_rs = 2 -> fwd_hit = 1, fwd_data = 0x2222; without the macro -> fwd_hit = 0, fwd_data = 0.
